jt1943_dwnld: RTL and testbench

Download sequencer for the 1943 core. It sits between the frame's ioctl byte stream and the game, and splits a single ROM file into three targets: SDRAM writes, the 32 kB sound ROM held in BRAM, and 256-byte colour/priority PROM write strobes. It produces the `prog_addr`/`prog_data`/`prom_we` bus that the game consumes during download, and it runs the SDRAM write handshake.

---
 rtl/jt1943_dwnld.sv | 247 ++++++++++++++++++++++++
 tb/tb_jt1943_dwnld.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt1943_dwnld.sv
// ----------------------------------------------------------------------------
// jt1943_dwnld
//
// Download sequencer for the 1943 core. Splits the single ROM file streamed
// over ioctl into three targets:
//   * SDRAM        (byte address below SND_START)   -> prog_we handshake
//   * sound ROM    (SND_START .. PROM_START-1)     -> prom_we[PROM_CNT-1] pulse
//   * colour PROMs (PROM_START and up, 256 B each) -> prom_we[k] pulse
// PROM strobe order (k = 0..11): 7l, 12l, 12a, 12m, 13a, 14a, 12c, 7f, 4b,
// 7c, 8c, 6l. PROM numbers past the last one are discarded.
//
// One entry is in flight (held on prog_addr/prog_data/prog_mask) and one more
// can wait in a pending slot. A byte arriving while the FSM is busy and the
// slot is full is dropped and raises the sticky dwnld_err flag.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   downloading              high while the ROM file streams
//   ioctl_addr/data/wr       byte stream from the frame
//   prog_addr/data/mask/we   SDRAM write request (we held until prog_rdy)
//   prog_rdy                 SDRAM write acknowledge
//   prom_we                  one-hot BRAM/PROM write pulse
//   dwnld_busy               downloading or work still pending
//   dwnld_err                sticky overrun flag
//   chksum                   16-bit additive checksum of accepted bytes
//
// Optional feature macro: JT1943_DWN_CHKSUM_EN builds the checksum adder;
// without it chksum is tied to zero.
// ----------------------------------------------------------------------------
module jt1943_dwnld #(
    parameter logic [21:0] SND_START  = 22'h2_0000,
    parameter logic [21:0] PROM_START = 22'h2_8000,
    parameter int          PROM_CNT   = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic [21:0]         ioctl_addr,
    input  logic [7:0]          ioctl_data,
    input  logic                ioctl_wr,
    output logic [21:0]         prog_addr,
    output logic [15:0]         prog_data,
    output logic [1:0]          prog_mask,
    output logic                prog_we,
    input  logic                prog_rdy,
    output logic [PROM_CNT-1:0] prom_we,
    output logic                dwnld_busy,
    output logic                dwnld_err,
    output logic [15:0]         chksum
);

    localparam logic [PROM_CNT-1:0] SEL_ONE  = {{(PROM_CNT-1){1'b0}}, 1'b1};
    localparam logic [PROM_CNT-1:0] SND_SEL  = {1'b1, {(PROM_CNT-1){1'b0}}};
    localparam logic [13:0]         PROM_NUM = 14'(PROM_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SDWR,
        ST_PROMWR
    } state_t;

    // Decoded entry: everything needed to drive the prog bus on dispatch.
    typedef struct packed {
        logic                sd;
        logic [21:0]         addr;
        logic [7:0]          data;
        logic [1:0]          mask;
        logic [PROM_CNT-1:0] sel;
    } entry_t;

    state_t              state_q, state_d;
    entry_t              slot_q, slot_d;
    logic                slot_full_q, slot_full_d;
    logic [21:0]         prog_addr_q, prog_addr_d;
    logic [15:0]         prog_data_q, prog_data_d;
    logic [1:0]          prog_mask_q, prog_mask_d;
    logic [PROM_CNT-1:0] prom_we_q, prom_we_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                dl_q, dl_d;

    entry_t              in_e;
    entry_t              nxt;
    logic                in_keep;
    logic [14:0]         snd_off;
    logic [21:0]         prom_off;
    logic [13:0]         prom_k;
    logic                acc;
    logic                fsm_busy;
    logic                ovr;
    logic                take;
    logic                go;
    logic                dl_rise;

    // Region decode of the incoming byte.
    always_comb begin
        in_e      = '0;
        in_e.data = ioctl_data;
        in_e.mask = 2'b11;
        in_keep   = 1'b0;
        // Only the low 15 bits of the sound offset matter, and they depend
        // only on the low 15 bits of the operands.
        snd_off   = ioctl_addr[14:0] - SND_START[14:0];
        prom_off  = ioctl_addr - PROM_START;
        prom_k    = prom_off[21:8];
        if (ioctl_addr < SND_START) begin
            in_e.sd   = 1'b1;
            in_e.addr = {1'b0, ioctl_addr[21:1]};
            in_e.mask = ioctl_addr[0] ? 2'b01 : 2'b10;
            in_keep   = 1'b1;
        end else if (ioctl_addr < PROM_START) begin
            in_e.addr = {7'd0, snd_off};
            in_e.sel  = SND_SEL;
            in_keep   = 1'b1;
        end else if (prom_k < PROM_NUM) begin
            in_e.addr = {14'd0, prom_off[7:0]};
            in_e.sel  = SEL_ONE << prom_k;
            in_keep   = 1'b1;
        end
    end

    // Next-state, dispatch and slot management.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        slot_full_d = slot_full_q;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        prog_mask_d = prog_mask_q;
        prom_we_d   = '0;
        go          = 1'b0;
        nxt         = in_e;

        acc      = downloading & ioctl_wr;
        fsm_busy = (state_q != ST_IDLE);
        ovr      = acc & fsm_busy & slot_full_q;
        // Discarded PROM bytes never occupy the slot.
        take     = acc & ~ovr & in_keep;

        case (state_q)
            ST_IDLE: begin
                if (slot_full_q) begin
                    go          = 1'b1;
                    nxt         = slot_q;
                    slot_full_d = take;
                    if (take) slot_d = in_e;
                end else if (take) begin
                    go  = 1'b1;
                    nxt = in_e;
                end
            end
            ST_SDWR: begin
                if (prog_rdy) begin
                    if (slot_full_q) begin
                        go          = 1'b1;
                        nxt         = slot_q;
                        slot_full_d = 1'b0;
                    end else if (take) begin
                        go  = 1'b1;
                        nxt = in_e;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (take) begin
                    slot_d      = in_e;
                    slot_full_d = 1'b1;
                end
            end
            ST_PROMWR: begin
                // Always pass through IDLE so every prom_we pulse is isolated.
                state_d = ST_IDLE;
                if (take) begin
                    slot_d      = in_e;
                    slot_full_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (go) begin
            state_d     = nxt.sd ? ST_SDWR : ST_PROMWR;
            prog_addr_d = nxt.addr;
            prog_data_d = {nxt.data, nxt.data};
            prog_mask_d = nxt.mask;
            prom_we_d   = nxt.sd ? '0 : nxt.sel;
        end

        dl_d    = downloading;
        dl_rise = downloading & ~dl_q;
        err_d   = ovr | (err_q & ~dl_rise);
        busy_d  = downloading | fsm_busy | slot_full_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            slot_full_q <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            prog_mask_q <= 2'b11;
            prom_we_q   <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            dl_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            slot_full_q <= slot_full_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            prog_mask_q <= prog_mask_d;
            prom_we_q   <= prom_we_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            dl_q        <= dl_d;
        end
    end

`ifdef JT1943_DWN_CHKSUM_EN
    logic [15:0] chk_q, chk_d;

    // Overrun bytes are excluded; discarded PROM bytes are still summed.
    always_comb begin
        chk_d = dl_rise ? 16'd0 : chk_q;
        if (acc && !ovr) chk_d = chk_d + {8'd0, ioctl_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chk_q <= '0;
        else        chk_q <= chk_d;
    end

    assign chksum = chk_q;
`else
    assign chksum = '0;
`endif

    assign prog_we    = (state_q == ST_SDWR);
    assign prog_addr  = prog_addr_q;
    assign prog_data  = prog_data_q;
    assign prog_mask  = prog_mask_q;
    assign prom_we    = prom_we_q;
    assign dwnld_busy = busy_q;
    assign dwnld_err  = err_q;

endmodule

// File: tb/tb_jt1943_dwnld.sv
module tb_jt1943_dwnld;

    localparam int SND = 32'h2_0000;
    localparam int PRM = 32'h2_8000;

    logic        clk;
    logic        rst_n;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prog_rdy;
    logic [12:0] prom_we;
    logic        dwnld_busy;
    logic        dwnld_err;
    logic [15:0] chksum;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_mode = 0;   // 0 manual, 1 random, 2 always high

    jt1943_dwnld dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .downloading(downloading),
        .ioctl_addr (ioctl_addr),
        .ioctl_data (ioctl_data),
        .ioctl_wr   (ioctl_wr),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_mask  (prog_mask),
        .prog_we    (prog_we),
        .prog_rdy   (prog_rdy),
        .prom_we    (prom_we),
        .dwnld_busy (dwnld_busy),
        .dwnld_err  (dwnld_err),
        .chksum     (chksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit          sd;
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
        logic [12:0] sel;
    } ent_t;

    ent_t        mq[$];      // mq[0] is in flight when m_act is set
    bit          m_act;
    logic [21:0] e_addr;
    logic [15:0] e_data;
    logic [1:0]  e_mask;
    bit          e_busy, e_err, e_dlp;
    logic [15:0] e_sum;

    function automatic bit mdecode(input int unsigned a, input logic [7:0] d, output ent_t e);
        int unsigned k;
        e.sd = 0; e.addr = '0; e.data = d; e.mask = 2'b11; e.sel = '0;
        if (a < SND) begin
            e.sd = 1; e.addr = 22'(a / 2); e.mask = (a % 2 == 1) ? 2'b01 : 2'b10;
            return 1;
        end
        if (a < PRM) begin
            e.addr = 22'(a - SND); e.sel = 13'h1000;
            return 1;
        end
        k = (a - PRM) / 256;
        if (k < 12) begin
            e.addr = 22'((a - PRM) % 256); e.sel = 13'(1 << k);
            return 1;
        end
        return 0;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_act = 0; e_addr = '0; e_data = '0; e_mask = 2'b11;
        e_busy = 0; e_err = 0; e_dlp = 0; e_sum = '0;
    endfunction

    initial begin : model
        ent_t ne;
        bit acc, ovr, rise, justp, keep;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else begin
                acc   = downloading && ioctl_wr;
                ovr   = acc && m_act && mq.size() == 2;
                rise  = downloading && !e_dlp;
                justp = 0;
                e_busy = downloading || m_act || mq.size() != 0;
                if (rise) e_sum = '0;
                if (acc && !ovr) e_sum = e_sum + 16'(ioctl_data);
                if (ovr) e_err = 1;
                else if (rise) e_err = 0;
                e_dlp = downloading;
                if (m_act) begin
                    if (!mq[0].sd || prog_rdy) begin
                        justp = !mq[0].sd;
                        void'(mq.pop_front());
                        m_act = 0;
                    end
                end
                if (acc && !ovr) begin
                    keep = mdecode(ioctl_addr, ioctl_data, ne);
                    if (keep) mq.push_back(ne);
                end
                if (!m_act && mq.size() != 0 && !justp) begin
                    m_act  = 1;
                    e_addr = mq[0].addr;
                    e_data = {mq[0].data, mq[0].data};
                    e_mask = mq[0].mask;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : cmp
        bit          x_we;
        logic [12:0] x_prom;
        logic [15:0] x_sum;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                x_we = 0; x_prom = '0;
                if (m_act) begin
                    if (mq[0].sd) x_we = 1;
                    else          x_prom = mq[0].sel;
                end
`ifdef JT1943_DWN_CHKSUM_EN
                x_sum = e_sum;
`else
                x_sum = '0;
`endif
                chk("m_prog_we",   32'(prog_we),    32'(x_we));
                chk("m_prom_we",   32'(prom_we),    32'(x_prom));
                chk("m_prog_addr", 32'(prog_addr),  32'(e_addr));
                chk("m_prog_data", 32'(prog_data),  32'(e_data));
                chk("m_prog_mask", 32'(prog_mask),  32'(e_mask));
                chk("m_busy",      32'(dwnld_busy), 32'(e_busy));
                chk("m_err",       32'(dwnld_err),  32'(e_err));
                chk("m_chksum",    32'(chksum),     32'(x_sum));
            end
        end
    end

    // prog_rdy responder
    initial begin : rdy_drv
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 1)      prog_rdy = ($urandom % 3 == 0);
            else if (rdy_mode == 2) prog_rdy = 1'b1;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input int unsigned a, input logic [7:0] d);
        ioctl_addr = 22'(a); ioctl_data = d; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic drain();
        ioctl_wr = 1'b0;
        rdy_mode = 2;
        repeat (6) tick();
        rdy_mode = 0;
        prog_rdy = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int unsigned r;
        rst_n = 1'b0; downloading = 1'b0; ioctl_addr = '0; ioctl_data = '0;
        ioctl_wr = 1'b0; prog_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_prog_we",   32'(prog_we),    32'd0);
        chk("rst_prom_we",   32'(prom_we),    32'd0);
        chk("rst_prog_addr", 32'(prog_addr),  32'd0);
        chk("rst_prog_data", 32'(prog_data),  32'd0);
        chk("rst_prog_mask", 32'(prog_mask),  32'd3);
        chk("rst_err",       32'(dwnld_err),  32'd0);
        chk("rst_chksum",    32'(chksum),     32'd0);
        rst_n = 1'b1;
        downloading = 1'b1;
        tick(); tick();

        // SDRAM write, ack four cycles later
        send(32'h3, 8'hA5);
        chk("sd_we",   32'(prog_we),   32'd1);
        chk("sd_addr", 32'(prog_addr), 32'd1);
        chk("sd_data", 32'(prog_data), 32'hA5A5);
        chk("sd_mask", 32'(prog_mask), 32'd1);
        tick(); tick(); tick();
        chk("sd_we_hold", 32'(prog_we), 32'd1);
        prog_rdy = 1'b1; tick(); prog_rdy = 1'b0;
        chk("sd_we_drop", 32'(prog_we),   32'd0);
        chk("sd_addr_kp", 32'(prog_addr), 32'd1);
        tick();

        // sound ROM
        send(SND + 32'h4001, 8'h3C);
        chk("snd_prom_we", 32'(prom_we),        32'h1000);
        chk("snd_addr",    32'(prog_addr),      32'h4001);
        chk("snd_data",    32'(prog_data[7:0]), 32'h3C);
        chk("snd_prog_we", 32'(prog_we),        32'd0);
        tick();
        chk("snd_pulse_end", 32'(prom_we), 32'd0);

        // PROM decode
        send(PRM + 32'h1FF, 8'h5A);
        chk("prom1_we",   32'(prom_we),   32'h0002);
        chk("prom1_addr", 32'(prog_addr), 32'hFF);
        tick();
        send(PRM + 32'hB00, 8'h77);
        chk("prom11_we",   32'(prom_we),   32'h0800);
        chk("prom11_addr", 32'(prog_addr), 32'h0);
        tick();
        send(PRM + 32'hC00, 8'h99);
        chk("prom12_none", 32'(prom_we),   32'd0);
        chk("prom12_data", 32'(prog_data), 32'h7777);
        tick();
        chk("prom12_none2", 32'(prom_we), 32'd0);

        // overrun: three SDRAM bytes back to back, ack withheld
        send(32'h10, 8'h11);
        send(32'h21, 8'h22);
        send(32'h32, 8'h33);
        chk("ovr_err",   32'(dwnld_err), 32'd1);
        chk("ovr_addr0", 32'(prog_addr), 32'h8);
        chk("ovr_data0", 32'(prog_data), 32'h1111);
        chk("ovr_mask0", 32'(prog_mask), 32'd2);
        repeat (8) tick();
        prog_rdy = 1'b1; tick(); prog_rdy = 1'b0;
        chk("ovr_we1",   32'(prog_we),   32'd1);
        chk("ovr_addr1", 32'(prog_addr), 32'h10);
        chk("ovr_data1", 32'(prog_data), 32'h2222);
        chk("ovr_mask1", 32'(prog_mask), 32'd1);
        tick();
        prog_rdy = 1'b1; tick(); prog_rdy = 1'b0;
        chk("ovr_third_dropped", 32'(prog_we),   32'd0);
        chk("ovr_addr_kept",     32'(prog_addr), 32'h10);
        downloading = 1'b0; tick();
        chk("err_sticky", 32'(dwnld_err), 32'd1);
        downloading = 1'b1; tick();
        chk("err_clear", 32'(dwnld_err), 32'd0);

        // drain after downloading falls
        send(32'h40, 8'hAA);
        send(32'h41, 8'hBB);
        downloading = 1'b0;
        tick(); tick();
        chk("drain_busy0", 32'(dwnld_busy), 32'd1);
        prog_rdy = 1'b1; tick(); prog_rdy = 1'b0;
        tick();
        chk("drain_busy1", 32'(dwnld_busy), 32'd1);
        chk("drain_addr",  32'(prog_addr),  32'h20);
        chk("drain_mask",  32'(prog_mask),  32'd1);
        prog_rdy = 1'b1; tick(); prog_rdy = 1'b0;
        chk("drain_we_off", 32'(prog_we),    32'd0);
        chk("drain_busy2",  32'(dwnld_busy), 32'd1);
        tick();
        chk("drain_idle", 32'(dwnld_busy), 32'd0);

        // reset in the middle of an SDRAM write
        downloading = 1'b1; tick();
        send(32'h7, 8'hC3);
        chk("rstmid_we_before", 32'(prog_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_we",   32'(prog_we),   32'd0);
        chk("rstmid_mask", 32'(prog_mask), 32'd3);
        chk("rstmid_addr", 32'(prog_addr), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // randomized traffic against the model
        rdy_mode = 1;
        for (int i = 0; i < 2000; i++) begin
            if (downloading && ($urandom % 150 == 0))      downloading = 1'b0;
            else if (!downloading && ($urandom % 8 == 0)) downloading = 1'b1;
            ioctl_wr   = 1'($urandom % 2);
            ioctl_data = 8'($urandom);
            r = $urandom % 4;
            if (r < 2)       ioctl_addr = 22'($urandom_range(0, SND - 1));
            else if (r == 2) ioctl_addr = 22'(SND + $urandom_range(0, 32'h7FFF));
            else             ioctl_addr = 22'(PRM + $urandom_range(0, 32'hFFF));
            tick();
        end
        downloading = 1'b1;
        drain();

`ifdef JT1943_DWN_CHKSUM_EN
        downloading = 1'b0; tick();
        downloading = 1'b1; tick();
        for (int i = 0; i < 257; i++) send(PRM + 32'hC00, 8'hFF);
        tick();
        chk("chksum_wrap", 32'(chksum), 32'hFFFF);
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
